// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the IF/EXE/WB pipeline: branch flush, load-use bubbles, data-memory wait.
// Optional PIPE_HAZARD_PERF_EN adds stall_cycles / flush_events performance counters.
module pipe_hazard_ctrl #(
    parameter int LOAD_BUBBLES = 1,
    parameter int MEM_TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  if_rs1,
    input  logic [4:0]  if_rs2,
    input  logic        if_uses_rs1,
    input  logic        if_uses_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_we,
    input  logic        ex_is_load,
    input  logic        br_taken,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        pc_stall,
    output logic        if2exe_stall,
    output logic        if2exe_flush,
    output logic        mem_timeout,
    output logic [1:0]  state_dbg
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
`endif
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_BUBBLE   = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    state_t     state_reg;
    logic [2:0] bub_cnt_reg;
    logic [7:0] wait_cnt_reg;
    logic       luh;
    logic       mem_miss;
    logic       wait_done;

    assign luh = ex_is_load && ex_reg_we && (ex_rd != 5'd0) &&
                 ((if_uses_rs1 && (if_rs1 == ex_rd)) || (if_uses_rs2 && (if_rs2 == ex_rd)));
    assign mem_miss  = dmem_req && !dmem_ready;
    assign wait_done = (wait_cnt_reg == 8'(MEM_TIMEOUT));
    assign state_dbg = state_reg;

    // Same-cycle control response; priority in RUN is memory > branch > load-use.
    always_comb begin
        pc_stall     = 1'b0;
        if2exe_stall = 1'b0;
        if2exe_flush = 1'b0;
        if (!rst) begin
            case (state_reg)
                ST_RUN: begin
                    if (mem_miss) begin
                        pc_stall     = 1'b1;
                        if2exe_stall = 1'b1;
                    end else if (br_taken) begin
                        if2exe_flush = 1'b1;
                    end else if (luh) begin
                        pc_stall     = 1'b1;
                        if2exe_flush = 1'b1;
                    end
                end
                ST_BUBBLE: begin
                    pc_stall     = 1'b1;
                    if2exe_flush = 1'b1;
                end
                ST_MEM_WAIT: begin
                    pc_stall     = !dmem_ready && !wait_done;
                    if2exe_stall = !dmem_ready && !wait_done;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_RUN;
            bub_cnt_reg  <= 3'd0;
            wait_cnt_reg <= 8'd0;
            mem_timeout  <= 1'b0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (mem_miss) begin
                        state_reg    <= ST_MEM_WAIT;
                        wait_cnt_reg <= 8'd1;
                    end else if (!br_taken && luh && (LOAD_BUBBLES > 1)) begin
                        state_reg   <= ST_BUBBLE;
                        bub_cnt_reg <= 3'(LOAD_BUBBLES - 1);
                    end
                end
                ST_BUBBLE: begin
                    bub_cnt_reg <= bub_cnt_reg - 3'd1;
                    // A zero count can only come from corruption; leave rather than wrap.
                    if (bub_cnt_reg <= 3'd1) begin
                        state_reg <= ST_RUN;
                    end
                end
                ST_MEM_WAIT: begin
                    if (dmem_ready) begin
                        state_reg <= ST_RUN;
                    end else if (wait_done) begin
                        state_reg   <= ST_RUN;
                        mem_timeout <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
                end
                default: state_reg <= ST_RUN;
            endcase
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= 32'd0;
            flush_events <= 32'd0;
        end else begin
            if (pc_stall) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (if2exe_flush) begin
                flush_events <= flush_events + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and stall controller for the three-stage IF/EXE/WB RV32I pipeline.
- Drives hold (stall) and bubble (flush) controls for the PC register and the IF-to-EXE pipeline register.
- Handles three cases: taken-branch/jump redirects, load-use dependencies, and multi-cycle data-memory accesses that use a req/ready handshake.
- Sits between the decode/control logic and the IF-to-EXE register.

Parameters:
- LOAD_BUBBLES, 1: bubbles inserted per load-use hazard; legal range 1..7.
- MEM_TIMEOUT, 15: maximum MEM_WAIT cycles before abort; legal range 2..255.

Ports:
- clk input 1: clock
- rst input 1: reset, synchronous, active-high
- if_rs1 input 5: rs1 field of the instruction in IF
- if_rs2 input 5: rs2 field of the instruction in IF
- if_uses_rs1 input 1: IF instruction reads rs1
- if_uses_rs2 input 1: IF instruction reads rs2
- ex_rd input 5: rd of the instruction in EXE
- ex_reg_we input 1: EXE instruction writes the register file
- ex_is_load input 1: EXE instruction is a load
- br_taken input 1: EXE resolved a taken branch or jump this cycle
- dmem_req input 1: EXE is issuing a data-memory access
- dmem_ready input 1: data memory completes the access this cycle
- pc_stall output 1: PC holds its value
- if2exe_stall output 1: IF-to-EXE register holds its contents
- if2exe_flush output 1: IF-to-EXE register loads zero (NOP bubble, all control fields 0)
- mem_timeout output 1: sticky flag, memory access aborted
- state_dbg output 2: current state (0 RUN, 1 BUBBLE, 2 MEM_WAIT)

Behaviour:
- Timing model: state, counters and mem_timeout are registered. pc_stall, if2exe_stall and if2exe_flush are combinational from state and inputs (same-cycle response).
- Reset: when rst=1 at a clock edge, next state=RUN, bub_cnt=0, wait_cnt=0, mem_timeout=0. All three control outputs are forced to 0 while rst=1. Reset mid-BUBBLE or mid-MEM_WAIT abandons the operation; the block is in RUN the next cycle.
- Load-use hazard: luh = ex_is_load & ex_reg_we & (ex_rd!=0) & ((if_uses_rs1 & if_rs1==ex_rd) | (if_uses_rs2 & if_rs2==ex_rd)).
- RUN, priority mem > branch > load-use:
  - dmem_req & !dmem_ready: pc_stall=1, if2exe_stall=1; next MEM_WAIT, wait_cnt<=1.
  - else br_taken: if2exe_flush=1, pc_stall=0; stay RUN. Branch beats a simultaneous luh.
  - else luh: pc_stall=1, if2exe_flush=1. If LOAD_BUBBLES>1, next BUBBLE with bub_cnt<=LOAD_BUBBLES-1; else stay RUN.
  - dmem_req & dmem_ready (single-cycle access): no stall.
  - otherwise all controls 0.
- BUBBLE:
  - pc_stall=1, if2exe_flush=1; bub_cnt decrements each cycle.
  - Next RUN when bub_cnt==1.
  - br_taken, dmem_req and luh are ignored (EXE holds a bubble).
- MEM_WAIT:
  - pc_stall = if2exe_stall = !dmem_ready; if2exe_flush=0; wait_cnt increments each cycle.
  - dmem_ready=1: stall released that cycle; next RUN.
  - wait_cnt==MEM_TIMEOUT with dmem_ready=0: stall released; mem_timeout<=1; next RUN.
  - br_taken ignored.
- mem_timeout stays 1 until reset.
- Invariants:
  - if2exe_stall=1 implies if2exe_flush=0.
  - state_dbg never equals 3; an illegal state recovers to RUN next cycle.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- With macro: adds output ports stall_cycles[31:0] and flush_events[31:0].
  - stall_cycles: counts cycles with pc_stall=1.
  - flush_events: counts cycles with if2exe_flush=1.
  - Both clear on rst and wrap modulo 2^32.
- Without macro: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Branch flush: br_taken=1 for one cycle in RUN -> if2exe_flush=1 and pc_stall=0 that cycle only; state stays 0.
- Load-use, LOAD_BUBBLES=1: ex_is_load=1, ex_reg_we=1, ex_rd=5, if_uses_rs2=1, if_rs2=5 -> pc_stall=1 and flush=1 for exactly 1 cycle. Same stimulus with ex_rd=0 -> no response.
- Load-use, LOAD_BUBBLES=3, with br_taken raised during BUBBLE -> flush=1 and pc_stall=1 for exactly 3 cycles; state 0,1,1,0; br_taken has no effect.
- Memory wait: dmem_req=1, dmem_ready low for 4 cycles then high -> pc_stall=if2exe_stall=1 for 4 cycles and 0 on the ready cycle; state returns to 0; mem_timeout=0.
- Timeout: dmem_req=1, dmem_ready=0 held, MEM_TIMEOUT=15 -> stall released after wait_cnt reaches 15; mem_timeout=1 and stays set; cleared only by rst.
- Simultaneous and reset: dmem_req & !dmem_ready together with br_taken and luh -> stall only, no flush. Asserting rst in MEM_WAIT -> all outputs 0 during rst; state 0 on the following cycle.
